// File: rtl/mul_div_unit.sv
// mul_div_unit
// Iterative unsigned multiply / divide unit. One operation at a time: a start
// pulse in IDLE latches the operands, then WIDTH iterations run (one multiplier
// bit or one quotient bit per cycle) before a single DONE cycle presents the
// results. Division by zero skips the iterations and reports immediately.
//
// Handshake: start is sampled only in IDLE. An accepted operation ends with a
// one-cycle done pulse; result/hi/div_by_zero are valid in that cycle, and
// result/hi keep their values until the next DONE. Nothing back-pressures done.
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   request an operation (honoured in IDLE only)
//   ALU_control  in   4'b0100 = MUL, 4'b0101 = DIV, anything else ignored
//   a, b         in   unsigned operands (multiplicand/dividend, multiplier/divisor)
//   busy         out  high while iterating (MUL or DIV state)
//   done         out  one-cycle result-valid pulse
//   result       out  low product / quotient
//   hi           out  high product / remainder
//   div_by_zero  out  high in the DONE cycle of a divide by zero
//   dbg_state    out  current FSM state encoding (IDLE=0, MUL=1, DIV=2, DONE=3)
module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ALU_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             div_by_zero,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST_ITER = CW'(WIDTH - 1);
    localparam logic [3:0]     OP_MUL    = 4'b0100;
    localparam logic [3:0]     OP_DIV    = 4'b0101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    // Shared working register.
    // MUL: {partial product high half, remaining multiplier bits}.
    // DIV: {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     res_q, res_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic                 dbz_q, dbz_d;

    // Shift-add step: add the multiplicand to the high half when the current
    // multiplier bit is set, then shift the whole register right by one. The
    // carry out of the add becomes the new MSB, so no product bit is lost.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;

    // Restoring division step: shift the next dividend bit into the remainder,
    // subtract the divisor if it fits, and shift the resulting quotient bit in.
    logic [WIDTH:0]       div_shift;
    logic                 div_fits;
    logic [WIDTH-1:0]     div_sub;
    logic [2*WIDTH-1:0]   div_next;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc_q[WIDTH-1:1]};

        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_fits  = (div_shift >= {1'b0, b_q});
        // When the divisor fits, the difference is below b and so fits in WIDTH bits.
        div_sub   = div_shift[WIDTH-1:0] - b_q;
        div_next  = {(div_fits ? div_sub : div_shift[WIDTH-1:0]), acc_q[WIDTH-2:0], div_fits};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        hi_d    = hi_q;
        dbz_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (ALU_control == OP_MUL) begin
                        a_d     = a;
                        b_d     = b;
                        cnt_d   = '0;
                        acc_d   = {{WIDTH{1'b0}}, b};
                        state_d = S_MUL;
                    end else if (ALU_control == OP_DIV) begin
                        if (b != '0) begin
                            a_d     = a;
                            b_d     = b;
                            cnt_d   = '0;
                            acc_d   = {{WIDTH{1'b0}}, a};
                            state_d = S_DIV;
                        end else begin
                            res_d   = '1;
                            hi_d    = a;
                            dbz_d   = 1'b1;
                            state_d = S_DONE;
                        end
                    end
                end
            end
            S_MUL: begin
                acc_d = mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    res_d   = mul_next[WIDTH-1:0];
                    hi_d    = mul_next[2*WIDTH-1:WIDTH];
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                acc_d = div_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    res_d   = div_next[WIDTH-1:0];
                    hi_d    = div_next[2*WIDTH-1:WIDTH];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            hi_q    <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            hi_q    <= hi_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == S_MUL) || (state_q == S_DIV);
    assign done        = (state_q == S_DONE);
    assign result      = res_q;
    assign hi          = hi_q;
    assign div_by_zero = dbz_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed vectors with hand-computed results pushed
// into an expected queue; a negedge monitor pops and compares on every done.
module tb_mul_div_unit;

    localparam int W = 32;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b0101;

    logic         clk;
    logic         rst;
    logic         start;
    logic [3:0]   ALU_control;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] hi;
    logic         div_by_zero;
    logic [1:0]   dbg_state;

    int checks_total  = 0;
    int checks_passed = 0;

    // {div_by_zero, hi, result}
    logic [2*W:0] exp_q[$];

    mul_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ALU_control (ALU_control),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .hi          (hi),
        .div_by_zero (div_by_zero),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- check helper ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks_total++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                logic [2*W:0] e;
                e = exp_q.pop_front();
                chk("sb_result", 64'(result), 64'(e[W-1:0]));
                chk("sb_hi", 64'(hi), 64'(e[2*W-1:W]));
                chk("sb_div_by_zero", 64'(div_by_zero), 64'(e[2*W]));
            end
        end
    end

    // ---------------- driver ----------------
    // Issues one operation; checks latency (edges after the accept edge until
    // done is visible), busy cycle count, and the return to IDLE. When inj >= 0
    // a MUL 3*3 start is pulsed during iteration inj.
    task automatic do_op(input string nm, input logic [3:0] ctrl,
                         input logic [W-1:0] oa, input logic [W-1:0] ob,
                         input logic [W-1:0] er, input logic [W-1:0] eh, input logic ed,
                         input int elat, input int ebusy, input int inj);
        int  lat;
        int  bcnt;
        bit  seen;
        lat  = 0;
        bcnt = 0;
        seen = 0;
        exp_q.push_back({ed, eh, er});
        @(negedge clk);
        start = 1'b1; ALU_control = ctrl; a = oa; b = ob;
        @(posedge clk);
        #1;
        start = 1'b0; ALU_control = 4'b0000; a = '0; b = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (inj >= 0 && lat == inj) begin
                start = 1'b1; ALU_control = OP_MUL; a = 32'd3; b = 32'd3;
            end else begin
                start = 1'b0; ALU_control = 4'b0000; a = '0; b = '0;
            end
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) bcnt++;
            lat++;
        end
        start = 1'b0;
        chk({nm, "_done_seen"}, 64'(seen), 64'd1);
        chk({nm, "_latency"}, 64'(lat), 64'(elat));
        chk({nm, "_busy_cycles"}, 64'(bcnt), 64'(ebusy));
        chk({nm, "_busy_in_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        chk({nm, "_done_one_cycle"}, 64'(done), 64'd0);
        chk({nm, "_back_idle"}, 64'(dbg_state), 64'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1; start = 1'b0; ALU_control = 4'b0000; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dbz", 64'(div_by_zero), 64'd0);
        rst = 1'b0;

        do_op("mul_7x6",   OP_MUL, 32'd7, 32'd6, 32'd42, 32'd0, 1'b0, W, W, -1);
        do_op("mul_max",   OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, W, W, -1);
        do_op("mul_shift", OP_MUL, 32'h1234_5678, 32'h10, 32'h2345_6780, 32'h1, 1'b0, W, W, -1);
        do_op("div_100_7", OP_DIV, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, W, W, -1);
        do_op("div_5_9",   OP_DIV, 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, W, W, -1);
        do_op("div_max_1", OP_DIV, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, W, W, -1);
        do_op("div_5_0",   OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 0, 0, -1);

        // Unsupported op code: ignored, previous results held.
        @(negedge clk);
        start = 1'b1; ALU_control = 4'b0110; a = 32'd9; b = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0; ALU_control = 4'b0000;
        @(negedge clk);
        chk("bad_op_state", 64'(dbg_state), 64'd0);
        chk("bad_op_busy", 64'(busy), 64'd0);
        chk("hold_result", 64'(result), 64'hFFFF_FFFF);
        chk("hold_hi", 64'(hi), 64'd5);
        chk("dbz_cleared", 64'(div_by_zero), 64'd0);

        // Second start during a running divide is ignored.
        do_op("div_inject", OP_DIV, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, W, W, 10);

        // Reset during iteration 16 of MUL 7*6 aborts with no done.
        @(negedge clk);
        start = 1'b1; ALU_control = OP_MUL; a = 32'd7; b = 32'd6;
        @(posedge clk);
        #1;
        start = 1'b0; ALU_control = 4'b0000;
        repeat (16) @(negedge clk);
        chk("pre_abort_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_result", 64'(result), 64'd0);
        chk("abort_hi", 64'(hi), 64'd0);
        chk("abort_dbz", 64'(div_by_zero), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (W + 2) begin
            @(negedge clk);
            chk("abort_no_done", 64'(done), 64'd0);
        end
        do_op("mul_2x3", OP_MUL, 32'd2, 32'd3, 32'd6, 32'd0, 1'b0, W, W, -1);

        repeat (2) @(negedge clk);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, request to begin an operation.
REQ-005 The block SHALL have port ALU_control, input, 4, operation select from the control decoder: 4'b0100 = MUL, 4'b0101 = DIV.
REQ-006 The block SHALL have ports a and b, input, WIDTH each, unsigned operands (a = multiplicand/dividend, b = multiplier/divisor).
REQ-007 The block SHALL have port busy, output, 1, high while an operation is iterating.
REQ-008 The block SHALL have port done, output, 1, one-cycle pulse marking valid results.
REQ-009 The block SHALL have port result, output, WIDTH: low product for MUL, quotient for DIV.
REQ-010 The block SHALL have port hi, output, WIDTH: high product for MUL, remainder for DIV.
REQ-011 The block SHALL have port div_by_zero, output, 1, exception flag for DIV with b = 0.

Function
REQ-012 The block SHALL implement an FSM with states IDLE, MUL, DIV and DONE.
REQ-013 In IDLE, start = 1 with ALU_control = 4'b0100 SHALL latch a and b, clear the iteration counter, and move to MUL.
REQ-014 In IDLE, start = 1 with ALU_control = 4'b0101 and b != 0 SHALL latch a and b and move to DIV.
REQ-015 In IDLE, start = 1 with ALU_control = 4'b0101 and b = 0 SHALL move directly to DONE.
  - In that case result = all ones, hi = a, and div_by_zero = 1 during the DONE cycle.
REQ-016 In IDLE, start = 1 with any other ALU_control value SHALL be ignored; the state stays IDLE.
REQ-017 start SHALL be ignored in MUL, DIV and DONE; operands latched at accept are not disturbed.
REQ-018 MUL SHALL be an iterative shift-add producing the full 2*WIDTH-bit unsigned product.
  - One multiplier bit is processed per cycle, for exactly WIDTH cycles.
REQ-019 DIV SHALL be iterative restoring division producing the unsigned quotient and remainder.
  - One quotient bit is produced per cycle, for exactly WIDTH cycles.
REQ-020 Latency: for an accept on edge N, the last iteration SHALL occur on edge N+WIDTH, which enters DONE.
  - done = 1 for exactly the cycle between edges N+WIDTH and N+WIDTH+1.
REQ-021 busy SHALL be 1 exactly while the state is MUL or DIV, and 0 in IDLE and DONE.
REQ-022 DONE SHALL return to IDLE on the next edge unconditionally.
REQ-023 result and hi SHALL be updated only on the edge entering DONE.
  - They hold their value until the next entry to DONE or reset.
REQ-024 div_by_zero SHALL be 1 only in a DONE cycle reached via REQ-015; otherwise 0.
REQ-025 The iteration counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL NOT wrap within an operation.
REQ-026 All arithmetic SHALL be unsigned; no output SHALL ever be X after reset.

Reset
REQ-027 When rst is asserted, asynchronously and regardless of clk:
  - state SHALL become IDLE;
  - busy, done and div_by_zero SHALL become 0;
  - result, hi, the latched operands and the counter SHALL become 0.
REQ-028 rst asserted mid-operation SHALL abort it with no done pulse.
  - The first edge after rst deassertion SHALL be able to accept a start.

Verification
REQ-029 MUL 7 * 6: done WIDTH cycles after the accept edge; result = 42, hi = 0, busy high for 32 cycles.
REQ-030 MUL 0xFFFFFFFF * 0xFFFFFFFF: result = 0x00000001, hi = 0xFFFFFFFE, div_by_zero = 0.
REQ-031 DIV 100 / 7: result = 14, hi = 2; DIV 5 / 9: result = 0, hi = 5.
REQ-032 DIV 5 / 0: done one cycle after accept, busy never 1, result = 0xFFFFFFFF, hi = 5, div_by_zero = 1.
REQ-033 Start DIV 100 / 7, then pulse start with MUL 3 * 3 at iteration 10: the second start is ignored and the outputs are result = 14, hi = 2.
REQ-034 Assert rst at iteration 16 of MUL 7 * 6: all outputs 0 immediately with no done; a new MUL 2 * 3 after release gives result = 6.
